// File: rtl/mux_scan_sequencer.sv
// Scans an external 8:1 mux through channels 0..7, settling before each
// sample, and hands the assembled byte to a consumer via valid/ready.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          CONT_MODE     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       y_in,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  localparam logic [3:0] SettleLd = 4'(SETTLE_CYCLES);
  localparam logic [2:0] LastIdx  = 3'd7;
  localparam logic [2:0] Park     = 3'b111;

  state_e     state_q;
  state_e     state_d;
  logic [2:0] idx_q;
  logic [2:0] idx_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic [7:0] shreg_q;
  logic [7:0] shreg_d;
  logic [7:0] dout_q;
  logic [7:0] dout_d;
  logic       valid_q;
  logic       valid_d;
  logic       scanning;
  logic [2:0] sel;

  // Next-state logic; abort wins over start and the output handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    if (abort) begin
      state_d = IDLE;
      idx_d   = 3'd0;
      cnt_d   = 4'd0;
      shreg_d = 8'h00;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = SETTLE;
            idx_d   = 3'd0;
            cnt_d   = SettleLd;
            shreg_d = 8'h00;
          end
        end
        SETTLE: begin
          if (cnt_q <= 4'd1) begin
            state_d = SAMPLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        SAMPLE: begin
          shreg_d[idx_q] = y_in;
          if (idx_q == LastIdx) begin
            dout_d  = {y_in, shreg_q[6:0]};
            valid_d = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            cnt_d   = SettleLd;
            state_d = SETTLE;
          end
        end
        DONE: begin
          if (data_ready) begin
            valid_d = 1'b0;
            if (CONT_MODE || start) begin
              state_d = SETTLE;
              idx_d   = 3'd0;
              cnt_d   = SettleLd;
              shreg_d = 8'h00;
            end else begin
              state_d = IDLE;
              idx_d   = 3'd0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 3'd0;
          cnt_d   = 4'd0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      shreg_q <= 8'h00;
      dout_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  // Select follows idx only while scanning; parked otherwise so that
  // channel 0 always starts with a select transition.
  always_comb begin
    scanning = (state_q == SETTLE) || (state_q == SAMPLE);
    sel      = scanning ? idx_q : Park;
  end

  assign s0         = sel[2];
  assign s1         = sel[1];
  assign s2         = sel[0];
  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1, range 1..15: the number of cycles the select is held before each sample.
REQ-002 The block SHALL have parameter CONT_MODE, default 0: when 1, a new scan starts automatically after each accepted word.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request one scan of channels 0..7.
REQ-006 The block SHALL have port abort, input, 1 bit: synchronous scan cancel.
REQ-007 The block SHALL have port y_in, input, 1 bit: the 8:1 multiplexer output being sampled.
REQ-008 The block SHALL have ports s0, s1, s2, outputs, 1 bit each: the multiplexer select, where {s0,s1,s2} is the channel index and s0 is the MSB.
REQ-009 The block SHALL have port data_out, output, 8 bits: the assembled word, where data_out[k] is the sample taken from channel k.
REQ-010 The block SHALL have port data_valid, output, 1 bit: data_out holds a complete word.
REQ-011 The block SHALL have port data_ready, input, 1 bit: the consumer accepts the word.
REQ-012 The block SHALL have port busy, output, 1 bit: high from scan acceptance until the word is accepted or the scan is aborted.

Function
REQ-013 The FSM SHALL have four states: IDLE, SETTLE, SAMPLE and DONE.
REQ-014 In IDLE and DONE, {s0,s1,s2} SHALL be parked at 3'b111, so that entering channel 0 is always a select transition.
REQ-015 When start=1 in IDLE, the FSM SHALL move to SETTLE with idx=0 and the settle counter loaded with SETTLE_CYCLES.
REQ-016 In SETTLE, {s0,s1,s2} SHALL equal idx, and the counter SHALL decrement each cycle; after exactly SETTLE_CYCLES cycles the FSM SHALL move to SAMPLE.
REQ-017 In SAMPLE (1 cycle), with select still equal to idx, the block SHALL capture shreg[idx] <= y_in.
REQ-018 After SAMPLE, if idx<7 the block SHALL set idx <= idx+1 and return to SETTLE with the counter reloaded.
REQ-019 After SAMPLE, if idx==7 the block SHALL load data_out from shreg (including the bit just sampled), set data_valid=1 and enter DONE.
REQ-020 Scan latency SHALL be 8*(SETTLE_CYCLES+1) cycles from the start edge to the last SAMPLE, with data_valid high on the following cycle; with the default, data_valid rises 17 cycles after the start edge.
REQ-021 In DONE, data_out and data_valid SHALL hold stable until data_valid & data_ready.
REQ-022 On the handshake, data_valid SHALL drop the next cycle.
REQ-023 On the handshake, if CONT_MODE=1 or start=1 the block SHALL go directly to SETTLE, idx=0; otherwise it SHALL go to IDLE.
REQ-024 data_ready SHALL be ignored outside DONE.
REQ-025 start SHALL be ignored in SETTLE and SAMPLE, with no queuing.
REQ-026 abort=1 in any state SHALL move the FSM to IDLE on the next edge, clearing data_valid, busy, idx and shreg, and parking select at 3'b111.
REQ-027 data_out SHALL retain its last value after an abort.
REQ-028 abort SHALL have priority over start and over the handshake in the same cycle.
REQ-029 busy SHALL equal 1 in SETTLE, SAMPLE and DONE, and 0 in IDLE.
REQ-030 idx SHALL never exceed 7; no wrap from 7 to 0 SHALL occur within a scan.

Reset
REQ-031 While rst_n=0, asynchronously: state=IDLE, idx=0, settle counter=0, shreg=8'h00, data_out=8'h00, data_valid=0, busy=0, {s0,s1,s2}=3'b111.
REQ-032 After rst_n deasserts, the first scan SHALL be accepted only on a clock edge that samples start=1.
REQ-033 Reset asserted mid-scan SHALL discard partial data, and no data_valid pulse SHALL follow.

Verification
REQ-034 Default parameters, mux inputs x0..x7 = 1,0,1,1,0,0,1,0, start pulse, data_ready=1 -> select sequence 000..111, each held 2 cycles; data_valid high 17 cycles after start; data_out=8'h4D for 1 cycle.
REQ-035 SETTLE_CYCLES=3, inputs giving 8'hA5, data_ready=0 for 10 cycles after valid -> each channel held 4 cycles; data_valid rises 33 cycles after start; data_out=8'hA5 held stable until data_ready=1, valid drops the next cycle.
REQ-036 CONT_MODE=1, data_ready tied 1, inputs changed from 8'hFF to 8'h00 after the first word -> back-to-back words 8'hFF then 8'h00; busy never deasserts; select goes 111->000 at each scan boundary.
REQ-037 abort asserted during SAMPLE at idx=4 together with start=1 -> IDLE next cycle, busy=0, select=111, no data_valid, data_out unchanged; a following start completes a normal scan.
REQ-038 rst_n pulsed low asynchronously at idx=5 -> outputs take reset values immediately (data_out=8'h00, select=111); start pulses during SETTLE/SAMPLE after recovery produce exactly one word per accepted start.
